sw_debounce_edge: RTL
=====================

// Module: sw_debounce_edge
// PURPOSE
//   Input-side conditioning for the board slide switches / push buttons.
//   Per channel: 2-FF synchronizer, debounce counter, then clean level,
//   one-cycle rise/fall pulses and a press-toggle state. Feeds the enable
//   inputs of the counter/LED toggle blocks in place of raw sw[] pins.
// PARAMETERS
//   NUM_CH  4   number of independent switch channels
//   CNT_W   32  width of debounce counter and threshold input
// PORTS
//   clk         in   1       system clock
//   reset       in   1       async, active-high; clears all state
//   i_db_th     in   CNT_W   debounce threshold, clk cycles of stability
//   sw          in   NUM_CH  raw asynchronous switch inputs
//   o_sw_level  out  NUM_CH  debounced level
//   o_rise      out  NUM_CH  1-cycle pulse on debounced 0->1
//   o_fall      out  NUM_CH  1-cycle pulse on debounced 1->0
//   o_toggle    out  NUM_CH  flips on every o_rise of its channel
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high. All flops are reset
//     asynchronously. Reset values: sync FFs 0, counters 0, o_sw_level 0,
//     o_rise 0, o_fall 0, o_toggle 0. All outputs are registered.
//   - Sync: s1 <= sw; s2 <= s1 (per channel). Only s2 is used downstream.
//   - Effective threshold th_eff = (i_db_th == 0) ? 1 : i_db_th.
//   - Per channel, per clk edge:
//       s2 == level          : cnt <= 0; no output change
//       s2 != level, cnt >= th_eff-1 : level <= s2; cnt <= 0;
//                              o_rise/o_fall <= 1 per direction
//       s2 != level, else    : cnt <= cnt + 1
//     o_rise/o_fall are 0 on every edge without a level update.
//     Rise and fall never assert together on one channel.
//   - ">=" compare: if i_db_th is lowered mid-count below cnt+1, the update
//     fires on the next mismatching edge; cnt never wraps.
//   - Latency: sw stable at new value before edge E0 -> o_sw_level and
//     the pulse change at edge E0 + 1 + th_eff (2 sync + th_eff filter).
//   - Glitch: any mismatch run shorter than th_eff cycles clears cnt and
//     leaves level/outputs unchanged.
//   - o_toggle <= ~o_toggle on the same edge o_rise is set; unchanged on fall.
//   - Channels are fully independent; simultaneous events on several
//     channels are handled in parallel with no interaction.
//   - Reset mid-count or mid-pulse: everything clears immediately; after
//     release a held-high sw produces o_rise again after 2+th_eff edges.
// TESTING
//   1. i_db_th=4, sw[0] 0->1 held -> o_sw_level[0]=1 and one o_rise[0]
//      pulse exactly 6 edges later; o_toggle[0]=1; other channels quiet.
//   2. i_db_th=4, sw[1] high for 3 cycles then low -> no level change,
//      no pulses; high 4+ cycles -> rise; then low 4+ cycles -> one fall.
//   3. i_db_th=0 and i_db_th=1 -> identical behaviour, latency 3 edges.
//   4. i_db_th=10, sw[2] high, after 5 mismatch cycles drop i_db_th to 3
//      -> update on next edge; cnt returns to 0, no wrap.
//   5. All 4 sw toggle in same cycle -> 4 simultaneous o_rise pulses; two
//      press/release cycles on sw[3] -> o_toggle[3] goes 1 then back to 0.
//   6. Assert reset mid-count and during an o_rise pulse -> all outputs 0
//      asynchronously; release with sw held high -> o_rise after 2+th_eff.

Source files
------------

// File: rtl/sw_debounce_edge.sv
// sw_debounce_edge
// Conditions raw slide-switch / push-button inputs. Each channel goes
// through a 2-FF synchronizer and a stability counter. The channel then
// produces a clean level, one-cycle rise and fall pulses, and a state bit
// that flips on every press.
module sw_debounce_edge #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  i_db_th,
  input  logic [NUM_CH-1:0] sw,
  output logic [NUM_CH-1:0] o_sw_level,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_toggle
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A threshold of zero makes no sense as "cycles of stability".
  // It is therefore treated as one, so a single mismatching sample is enough.
  function automatic logic [CNT_W-1:0] eff_threshold(input logic [CNT_W-1:0] th);
    eff_threshold = (th == '0) ? CNT_ONE : th;
  endfunction

  logic [NUM_CH-1:0] sync_p0;
  logic [NUM_CH-1:0] sync_p1;
  logic [CNT_W-1:0]  cnt_p2 [NUM_CH];
  logic [CNT_W-1:0]  th_last;

  // Fire point is one below the effective threshold, because the counter
  // holds the number of mismatching edges seen *before* the current one.
  always_comb begin
    th_last = eff_threshold(i_db_th) - CNT_ONE;
  end

  // ---- stage p0/p1: two-flop synchronizer for the asynchronous pins ----
  // Capture raw pins, then re-register to resolve metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: stability filter, level, edge pulses, press toggle ----
  // Count consecutive disagreeing samples and commit the new level once the
  // run is long enough. Any agreeing sample discards the run. The ">="
  // compare lets a lowered threshold take effect at once. It also stops the
  // counter from running past the fire point, so the counter cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_sw_level <= '0;
      o_rise     <= '0;
      o_fall     <= '0;
      o_toggle   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_p2[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        o_rise[c] <= 1'b0;
        o_fall[c] <= 1'b0;
        if (sync_p1[c] == o_sw_level[c]) begin
          cnt_p2[c] <= '0;
        end else if (cnt_p2[c] >= th_last) begin
          o_sw_level[c] <= sync_p1[c];
          cnt_p2[c]     <= '0;
          o_rise[c]     <= sync_p1[c];
          o_fall[c]     <= ~sync_p1[c];
          if (sync_p1[c]) begin
            o_toggle[c] <= ~o_toggle[c];
          end
        end else begin
          cnt_p2[c] <= cnt_p2[c] + CNT_ONE;
        end
      end
    end
  end

endmodule
